// File: rtl/tdm_demux.sv
// Receive end of a serial TDM link: frames WIDTH-bit slots from a
// synced bit stream into per-channel registers with completion strobes.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      din,
  input  logic                      din_valid,
  input  logic                      sync,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(CHANNELS);
  localparam int SW = WIDTH - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                    state_q;
  logic [BW-1:0]             bit_cnt_q;
  logic [CW-1:0]             ch_cnt_q;
  // din completes the slot, so only the first WIDTH-1 bits are held
  logic [SW-1:0]             shreg_q;
  logic [CHANNELS*WIDTH-1:0] ch_data_q;
  logic [CHANNELS-1:0]       ch_valid_q;
  logic                      frame_done_q;
  logic                      frame_err_q;
  logic                      busy_q;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      shreg_q      <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          IDLE: begin
            if (sync) begin
              shreg_q   <= SW'(din);
              bit_cnt_q <= BW'(1);
              ch_cnt_q  <= '0;
              state_q   <= SHIFT;
              busy_q    <= 1'b1;
            end
          end
          SHIFT: begin
            if (sync) begin
              // resync: drop partial slot, this bit starts channel 0
              frame_err_q <= 1'b1;
              shreg_q     <= SW'(din);
              bit_cnt_q   <= BW'(1);
              ch_cnt_q    <= '0;
            end else if (bit_cnt_q == BW'(WIDTH - 1)) begin
              shreg_q   <= SW'({shreg_q, din});
              bit_cnt_q <= '0;
              for (int k = 0; k < CHANNELS; k++) begin
                if (ch_cnt_q == CW'(k)) begin
                  ch_data_q[k*WIDTH +: WIDTH] <= {shreg_q, din};
                  ch_valid_q[k]               <= 1'b1;
                end
              end
              if (ch_cnt_q == CW'(CHANNELS - 1)) begin
                frame_done_q <= 1'b1;
                ch_cnt_q     <= '0;
                state_q      <= IDLE;
                busy_q       <= 1'b0;
              end else begin
                ch_cnt_q <= ch_cnt_q + CW'(1);
              end
            end else begin
              shreg_q   <= SW'({shreg_q, din});
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
